// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Holds the scan state encoding and the active-low hex segment table.
package seg_scan_pkg;

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } state_t;

    // Segment vectors are active-low, bit6=a ... bit0=g.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, // 0
        7'b1001111, // 1
        7'b0010010, // 2
        7'b0000110, // 3
        7'b1001100, // 4
        7'b0100100, // 5
        7'b0100000, // 6
        7'b0001111, // 7
        7'b0000000, // 8
        7'b0001100, // 9
        7'b0001000, // A
        7'b1100000, // b
        7'b0110001, // C
        7'b1000010, // d
        7'b0110000, // E
        7'b0111000  // F
    };

    // Counter width able to hold 0..max_val-1, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/seg_hex_dec.sv
// Combinational hex-to-segment decoder using the shared active-low table.
module seg_hex_dec
    import seg_scan_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits.
// Define SEG_SCAN_BLINK_EN to add blink_mask and a frame-based blink phase.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYC    = 500
`ifdef SEG_SCAN_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_idx,
    input  logic [3:0]                    wr_data,
    input  logic [NUM_DIGITS-1:0]         dig_en,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [NUM_DIGITS-1:0]         blink_mask,
`endif
    output logic [6:0]                    seg,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          frame_tick
);

    localparam int PW      = $clog2(NUM_DIGITS);
    localparam int CNT_MAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
    localparam int CW      = cnt_width(CNT_MAX);

    localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [PW-1:0] PTR_LAST   = PW'(NUM_DIGITS - 1);

    state_t          state, next_state;
    logic [PW-1:0]   ptr, next_ptr;
    logic [CW-1:0]   cnt, next_cnt;
    logic            frame_end;

    logic [3:0]      mem [NUM_DIGITS];
    logic [6:0]      dec_seg;
    logic [NUM_DIGITS-1:0] eff_en;

    // ------------------------------------------------------------------
    // Digit storage
    // ------------------------------------------------------------------
    // NOTE: the storage array is explicitly reset because cleared digits on
    // reset are part of the visible behaviour, not just a simulation nicety.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && (int'(wr_idx) < NUM_DIGITS)) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM: state register
    // ------------------------------------------------------------------
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SHOW;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= next_state;
            ptr   <= next_ptr;
            cnt   <= next_cnt;
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        next_state = state;
        next_ptr   = ptr;
        next_cnt   = cnt + CW'(1);
        frame_end  = 1'b0;

        unique case (state)
            SHOW: begin
                if (cnt == SHOW_LAST) begin
                    next_state = BLANK;
                    next_cnt   = '0;
                end
            end
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    next_state = SHOW;
                    next_cnt   = '0;
                    if (ptr == PTR_LAST) begin
                        next_ptr  = '0;
                        frame_end = 1'b1;
                    end else begin
                        next_ptr  = ptr + PW'(1);
                    end
                end
            end
            default: begin
                next_state = SHOW;
                next_cnt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Effective digit enable (optionally gated by the blink phase)
    // ------------------------------------------------------------------
`ifdef SEG_SCAN_BLINK_EN
    localparam int BW = cnt_width(BLINK_FRAMES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] frame_cnt;
    logic          blink_off;

    // Counts on the same condition that raises frame_tick, so the new phase
    // lines up with the first digit of the following frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            blink_off <= 1'b0;
        end else if (frame_end) begin
            if (frame_cnt == BLINK_LAST) begin
                frame_cnt <= '0;
                blink_off <= ~blink_off;
            end else begin
                frame_cnt <= frame_cnt + BW'(1);
            end
        end
    end

    assign eff_en = dig_en & ~(blink_mask & {NUM_DIGITS{blink_off}});
`else
    assign eff_en = dig_en;
`endif

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    seg_hex_dec u_dec (
        .hex (mem[ptr]),
        .seg (dec_seg)
    );

    // A disabled digit keeps its full SHOW slot so brightness stays uniform.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= SEG_OFF;
            an         <= '1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            if (state == SHOW && eff_en[ptr]) begin
                seg <= dec_seg;
                an  <= ~(NUM_DIGITS'(1) << ptr);
            end else begin
                seg <= SEG_OFF;
                an  <= '1;
            end
        end
    end

endmodule
